// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control and the multiply/divide sequencer.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [1:0] HILO_SEL_ALU = 2'b00;
    localparam logic [1:0] HILO_SEL_HI  = 2'b01;
    localparam logic [1:0] HILO_SEL_LO  = 2'b10;

    typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;

    // mult/multu/div/divu share the 0110xx pattern: bit1 = divide, bit0 = unsigned
    function automatic logic is_md_funct(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/alu_mdu_ctrl_md_iter.sv
// One-bit-per-cycle unsigned multiply (shift-add) / restoring divide step datapath.
module md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] sr
);

    logic [WIDTH-1:0] b_r;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // mult: {acc,sr} is the product shifting right; div: acc = remainder, sr = dividend->quotient
    always_comb begin
        sum    = {1'b0, acc} + (sr[0] ? {1'b0, b_r} : '0);
        rem_sh = {acc, sr[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sr  <= '0;
            b_r <= '0;
        end else if (load) begin
            acc <= '0;
            sr  <= a_in;
            b_r <= b_in;
        end else if (step) begin
            if (is_div) begin
                if (!diff[WIDTH]) begin
                    acc <= diff[WIDTH-1:0];
                    sr  <= {sr[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= rem_sh[WIDTH-1:0];
                    sr  <= {sr[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc <= sum[WIDTH:1];
                sr  <= {sum[0], sr[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// EX-stage ALU select decode plus iterative MULT/DIV sequencer with HI/LO and stall.
module alu_mdu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             valid_in,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             sub,
    output logic             sel_logic,
    output logic             sel_or,
    output logic             sel_slt,
    output logic [1:0]       sel_hilo,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t        state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             is_md, is_mfx, accept, fix_we;
    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, acc, sr;
    logic             op_div_r, neg_res_r, neg_rem_r, b_zero_r;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
        sub       = 1'b0;
        sel_logic = 1'b0;
        sel_or    = 1'b0;
        sel_slt   = 1'b0;
        sel_hilo  = HILO_SEL_ALU;
        is_mfx    = 1'b0;
        case (alu_op)
            ALUOP_SUB: sub = 1'b1;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_SUB: sub = 1'b1;
                    FUNCT_AND: sel_logic = 1'b1;
                    FUNCT_OR: begin
                        sel_logic = 1'b1;
                        sel_or    = 1'b1;
                    end
                    FUNCT_SLT: begin
                        sub     = 1'b1;
                        sel_slt = 1'b1;
                    end
                    FUNCT_MFHI: begin
                        sel_hilo = HILO_SEL_HI;
                        is_mfx   = 1'b1;
                    end
                    FUNCT_MFLO: begin
                        sel_hilo = HILO_SEL_LO;
                        is_mfx   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign is_md     = (alu_op == ALUOP_RTYPE) && is_md_funct(funct);
    assign op_signed = ~funct[0];
    assign a_neg     = op_signed & op_a[WIDTH-1];
    assign b_neg     = op_signed & op_b[WIDTH-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;

    assign accept  = (state == IDLE) & valid_in & is_md & ~flush;
    assign fix_we  = (state == FIX) & ~flush;
    assign stall   = valid_in & (state != IDLE) & (is_md | is_mfx);
    assign md_busy = (state != IDLE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = CALC;
            CALC:    if (cnt == CNT_W'(1)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            b_zero_r  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt       <= CNT_W'(WIDTH);
                op_div_r  <= funct[1];
                neg_res_r <= a_neg ^ b_neg;
                neg_rem_r <= a_neg;
                b_zero_r  <= (op_b == '0);
            end else if (state == CALC) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (state == CALC),
        .is_div (op_div_r),
        .a_in   (a_mag),
        .b_in   (b_mag),
        .acc    (acc),
        .sr     (sr)
    );

    // Divide-by-zero forces an all-ones quotient; the remainder already holds |op_a|
    always_comb begin
        prod     = {acc, sr};
        prod_fix = neg_res_r ? -prod : prod;
        quo_fix  = b_zero_r ? '1 : (neg_res_r ? -sr : sr);
        rem_fix  = neg_rem_r ? -acc : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            md_done <= 1'b0;
        end else begin
            md_done <= fix_we;
            if (fix_we) begin
                if (op_div_r) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed bench for alu_mdu_ctrl: decode table, mult/div results, hazards, flush and reset.
module tb_alu_mdu_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic         valid_in, flush;
    logic [W-1:0] op_a, op_b;
    logic         sub, sel_logic, sel_or, sel_slt, stall, md_busy, md_done;
    logic [1:0]   sel_hilo;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_mdu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct(funct),
        .valid_in(valid_in), .flush(flush), .op_a(op_a), .op_b(op_b),
        .sub(sub), .sel_logic(sel_logic), .sel_or(sel_or), .sel_slt(sel_slt),
        .sel_hilo(sel_hilo), .stall(stall), .md_busy(md_busy), .md_done(md_done),
        .hi(hi), .lo(lo)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one MD op, return edges-to-done (accept edge counted), results and a late-done flag
    task automatic md_run(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int n, output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                          output logic done_after);
        alu_op = 2'b10; funct = f; op_a = a; op_b = b; valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        n = 1;
        while (!md_done && n < 200) begin
            tick;
            n++;
        end
        rhi = hi;
        rlo = lo;
        tick;
        done_after = md_done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; valid_in = 1'b1; alu_op = 2'b10; funct = 6'b011000;
        op_a = 32'd5; op_b = 32'd6;
        #12;
        checks++;
        if ({hi, lo} !== '0) begin
            errors++; $display("FAIL reset_hilo: got hi=%h lo=%h, want 0", hi, lo);
        end
        checks++;
        if ({stall, md_busy, md_done} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got stall/busy/done=%b, want 000", {stall, md_busy, md_done});
        end
        valid_in = 1'b0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_decode;
        logic [1:0] ops [13];
        logic [5:0] fns [13];
        logic [5:0] exp [13];
        logic [5:0] got;
        ops = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        fns = '{6'b000000, 6'b000000, 6'b000000, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b101010, 6'b010000, 6'b010010, 6'b111111, 6'b011000, 6'b101010};
        // {sub, sel_logic, sel_or, sel_slt, sel_hilo}
        exp = '{6'b000000, 6'b100000, 6'b000000, 6'b000000, 6'b100000, 6'b010000, 6'b011000,
                6'b100100, 6'b000001, 6'b000010, 6'b000000, 6'b000000, 6'b100000};
        for (int i = 0; i < 13; i++) begin
            alu_op = ops[i]; funct = fns[i];
            #1;
            got = {sub, sel_logic, sel_or, sel_slt, sel_hilo};
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL decode[%0d] op=%b f=%b: got %b, want %b", i, ops[i], fns[i], got, exp[i]);
            end
        end
    endtask

    task automatic test_mult;
        int n; logic [W-1:0] rh, rl; logic late;
        md_run(6'b011001, 32'hFFFF_FFFF, 32'd2, n, rh, rl, late);
        checks++;
        if (n !== 34) begin errors++; $display("FAIL multu_latency: got %0d, want 34", n); end
        checks++;
        if ({rh, rl} !== {32'h0000_0001, 32'hFFFF_FFFE}) begin
            errors++; $display("FAIL multu_result: got hi=%h lo=%h, want 00000001 fffffffe", rh, rl);
        end
        checks++;
        if (late !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: done still %b, want 0", late); end
        md_run(6'b011000, -32'sd3, 32'd5, n, rh, rl, late);
        checks++;
        if ({rh, rl} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
            errors++; $display("FAIL mult_signed: got hi=%h lo=%h, want ffffffff fffffff1", rh, rl);
        end
    endtask

    task automatic test_div;
        int n; logic [W-1:0] rh, rl; logic late;
        md_run(6'b011010, -32'sd7, 32'd2, n, rh, rl, late);
        checks++;
        if ({rh, rl} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            errors++; $display("FAIL div_signed: got hi=%h lo=%h, want ffffffff fffffffd", rh, rl);
        end
        md_run(6'b011011, 32'd7, 32'd0, n, rh, rl, late);
        checks++;
        if ({rh, rl} !== {32'h0000_0007, 32'hFFFF_FFFF} || n !== 34) begin
            errors++; $display("FAIL divu_by_zero: got hi=%h lo=%h n=%0d, want 00000007 ffffffff 34", rh, rl, n);
        end
        md_run(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, n, rh, rl, late);
        checks++;
        if ({rh, rl} !== {32'h0000_0000, 32'h8000_0000}) begin
            errors++; $display("FAIL div_overflow: got hi=%h lo=%h, want 00000000 80000000", rh, rl);
        end
        md_run(6'b011011, 32'd100, 32'd7, n, rh, rl, late);
        checks++;
        if ({rh, rl} !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL divu_basic: got hi=%h lo=%h, want 2 14", rh, rl);
        end
    endtask

    task automatic test_hazard;
        int n; int bad; logic add_stall;
        bad = 0; add_stall = 1'b1;
        alu_op = 2'b10; funct = 6'b011000; op_a = 32'd7; op_b = 32'd6; valid_in = 1'b1;
        tick;
        n = 1;
        while (!md_done && n < 200) begin
            funct = (n == 5) ? 6'b100000 : 6'b010010;
            #1;
            if (n == 5) add_stall = stall;
            else if (stall !== 1'b1) bad++;
            tick;
            n++;
        end
        funct = 6'b010010;
        #1;
        checks++;
        if (bad !== 0 || n !== 34) begin
            errors++; $display("FAIL hazard_stall: %0d cycles unstalled, n=%0d, want 0 and 34", bad, n);
        end
        checks++;
        if (add_stall !== 1'b0) begin errors++; $display("FAIL hazard_add: stall=%b, want 0", add_stall); end
        checks++;
        if ({stall, sel_hilo, lo} !== {1'b0, 2'b10, 32'd42}) begin
            errors++; $display("FAIL hazard_mflo: got stall=%b sel=%b lo=%0d, want 0 10 42", stall, sel_hilo, lo);
        end
        valid_in = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        int n;
        logic [W-1:0] h1, l1;
        alu_op = 2'b10; funct = 6'b011001; op_a = 32'd9; op_b = 32'd9; valid_in = 1'b1;
        tick;
        funct = 6'b011011; op_a = 32'd50; op_b = 32'd8;
        n = 1;
        while (!md_done && n < 200) begin tick; n++; end
        h1 = hi; l1 = lo;
        #1;
        checks++;
        if ({stall, h1, l1} !== {1'b0, 32'd0, 32'd81}) begin
            errors++; $display("FAIL b2b_first: got stall=%b hi=%0d lo=%0d, want 0 0 81", stall, h1, l1);
        end
        tick;
        valid_in = 1'b0;
        n = 1;
        while (!md_done && n < 200) begin tick; n++; end
        checks++;
        if ({hi, lo, n} !== {32'd2, 32'd6, 32'd34}) begin
            errors++; $display("FAIL b2b_second: got hi=%0d lo=%0d n=%0d, want 2 6 34", hi, lo, n);
        end
        tick;
    endtask

    task automatic test_flush;
        logic [W-1:0] h0, l0; int dones;
        h0 = hi; l0 = lo; dones = 0;
        alu_op = 2'b10; funct = 6'b011000; op_a = 32'd3; op_b = 32'd3; valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        valid_in = 1'b1; funct = 6'b010000;
        #1;
        checks++;
        if ({md_busy, stall} !== 2'b00) begin
            errors++; $display("FAIL flush_idle: got busy/stall=%b, want 00", {md_busy, stall});
        end
        valid_in = 1'b0;
        repeat (40) begin tick; if (md_done) dones++; end
        checks++;
        if ({hi, lo} !== {h0, l0} || dones !== 0) begin
            errors++; $display("FAIL flush_hold: got hi=%h lo=%h dones=%0d, want %h %h 0", hi, lo, dones, h0, l0);
        end
        funct = 6'b011000; valid_in = 1'b1; flush = 1'b1;
        tick;
        valid_in = 1'b0; flush = 1'b0;
        checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL flush_accept: busy=%b, want 0", md_busy); end
    endtask

    task automatic test_reset_mid;
        alu_op = 2'b10; funct = 6'b011001; op_a = 32'd11; op_b = 32'd13; valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        repeat (5) tick;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hi, lo, md_busy} !== '0) begin
            errors++; $display("FAIL reset_mid: got hi=%h lo=%h busy=%b, want 0 0 0", hi, lo, md_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_decode;
        test_mult;
        test_div;
        test_hazard;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
